sha256_padder: RTL and testbench



---
 rtl/sha256_pkg.sv | 30 +++
 rtl/sha256_padder.sv | 125 ++++++++++++
 tb/tb_sha256_padder.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/sha256_pkg.sv
// Shared constants, state type and marker helper for the SHA-256 message padder.
package sha256_pkg;

  localparam int WORD_W          = 32;
  localparam int BLOCK_W         = 512;
  localparam int WORDS_PER_BLOCK = 16;
  localparam int LEN_W           = 64;

  localparam logic [7:0] PAD_MARKER = 8'h80;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    EMIT  = 2'd1,
    EXTRA = 2'd2
  } pad_state_t;

  // Keep the first nb message bytes of a word, place the 0x80 marker right
  // after them and zero everything below.
  function automatic logic [31:0] mark_word(input logic [31:0] w, input logic [1:0] nb);
    logic [31:0] r;
    case (nb)
      2'd0:    r = {PAD_MARKER, 24'h0};
      2'd1:    r = {w[31:24], PAD_MARKER, 16'h0};
      2'd2:    r = {w[31:16], PAD_MARKER, 8'h0};
      default: r = {w[31:8], PAD_MARKER};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sha256_padder.sv
// SHA-256 message padder: packs 32-bit big-endian words into 512-bit blocks,
// inserts the 0x80 marker, zero fill and 64-bit bit length, and tags the
// first/final block of every message.
module sha256_padder #(
  parameter int BLOCK_W = 512,
  parameter int WORD_W  = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WORD_W-1:0]  in_data,
  input  logic               in_last,
  input  logic [2:0]         in_bytes,
  output logic               blk_valid,
  input  logic               blk_ready,
  output logic [BLOCK_W-1:0] blk_data,
  output logic               blk_first,
  output logic               blk_final
);
  import sha256_pkg::*;

  localparam int NW = BLOCK_W / WORD_W;

  pad_state_t        r_state, w_state_nxt;
  logic              r_rdy;
  logic [WORD_W-1:0] r_buf [NW];
  logic [3:0]        r_widx;
  logic [63:0]       r_len;
  logic [4:0]        r_k;       // word index of the marker (16 = next block)
  logic [1:0]        r_mbyte;   // byte position of the marker inside word r_k
  logic              r_last;    // buffered block ends the message
  logic              r_first;

  logic              w_in_fire, w_blk_fire, w_emit_final, w_msg_done;
  logic [2:0]        w_nbytes;
  logic [63:0]       w_bitlen;
  logic [WORD_W-1:0] w_words [NW];

  assign w_in_fire    = in_valid && r_rdy;
  assign w_blk_fire   = blk_valid && blk_ready;
  assign w_nbytes     = !in_last ? 3'd4 : (in_bytes > 3'd4 ? 3'd4 : in_bytes);
  assign w_emit_final = r_last && (r_k <= 5'd13);
  assign w_msg_done   = w_blk_fire && ((r_state == EMIT && w_emit_final) || r_state == EXTRA);
  assign w_bitlen     = r_len << 3;

  // Next-state decode: a block is pending in EMIT/EXTRA until its handshake.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      FILL:    if (w_in_fire && (in_last || r_widx == 4'd15)) w_state_nxt = EMIT;
      EMIT:    if (w_blk_fire) w_state_nxt = (r_last && !w_emit_final) ? EXTRA : FILL;
      EXTRA:   if (w_blk_fire) w_state_nxt = FILL;
      default: w_state_nxt = FILL;
    endcase
  end

  // Control state, word index, byte counter, marker position and first flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= FILL;
      r_rdy   <= 1'b0;
      r_widx  <= '0;
      r_len   <= '0;
      r_k     <= '0;
      r_mbyte <= '0;
      r_last  <= 1'b0;
      r_first <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_rdy   <= (w_state_nxt == FILL);
      if (w_in_fire) begin
        r_widx <= r_widx + 4'd1;
        r_len  <= r_len + 64'(w_nbytes);
        r_last <= in_last;
        if (in_last) begin
          r_k     <= (w_nbytes == 3'd4) ? {1'b0, r_widx} + 5'd1 : {1'b0, r_widx};
          r_mbyte <= (w_nbytes == 3'd4) ? 2'd0 : w_nbytes[1:0];
        end
      end
      if (w_blk_fire) begin
        r_first <= w_msg_done;
        if (w_msg_done) begin
          r_widx <= '0;
          r_len  <= '0;
          r_last <= 1'b0;
        end
      end
    end
  end

  // Word buffer; stale contents are hidden by the output mask, so no reset.
  always_ff @(posedge clock) begin
    if (w_in_fire) r_buf[r_widx] <= in_data;
  end

  // Output mask: data, marker, zero fill and length per block type.
  always_comb begin
    for (int i = 0; i < NW; i++) begin
      w_words[i] = '0;
      if (r_state == EMIT) begin
        if (!r_last || 5'(i) < r_k)  w_words[i] = r_buf[i];
        else if (5'(i) == r_k)       w_words[i] = mark_word(r_buf[i], r_mbyte);
        if (w_emit_final && i == 14) w_words[i] = w_bitlen[63:32];
        if (w_emit_final && i == 15) w_words[i] = w_bitlen[31:0];
      end else if (r_state == EXTRA) begin
        if (i == 0 && r_k == 5'd16) w_words[i] = {PAD_MARKER, 24'h0};
        if (i == 14)                w_words[i] = w_bitlen[63:32];
        if (i == 15)                w_words[i] = w_bitlen[31:0];
      end
    end
  end

  // Word 0 occupies the top of the block.
  always_comb begin
    blk_data = '0;
    for (int i = 0; i < NW; i++) blk_data[BLOCK_W-1-WORD_W*i -: WORD_W] = w_words[i];
  end

  assign in_ready  = r_rdy;
  assign blk_valid = (r_state != FILL);
  assign blk_first = r_first;
  assign blk_final = (r_state == EXTRA) || (r_state == EMIT && w_emit_final);

endmodule

// File: tb/tb_sha256_padder.sv
// Directed bench for sha256_padder: hand-computed padded blocks plus a
// byte-level FIPS 180-4 padding model for synthetic messages.
module tb_sha256_padder;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [31:0]  in_data = '0;
  logic         in_last = 1'b0;
  logic [2:0]   in_bytes = '0;
  logic         blk_valid;
  logic         blk_ready = 1'b0;
  logic [511:0] blk_data;
  logic         blk_first;
  logic         blk_final;

  sha256_padder #(.BLOCK_W(512), .WORD_W(32)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .in_bytes(in_bytes),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
    .blk_first(blk_first), .blk_final(blk_final)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  logic [511:0] rx_data [2];
  logic         rx_first [2];
  logic         rx_final [2];

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] wd(input logic [511:0] b, input int i);
    return b[511-32*i -: 32];
  endfunction

  // Reference padding of an n-byte message whose byte j equals j mod 256.
  function automatic logic [7:0] pad_byte(input int n, input int j);
    int total;
    logic [63:0] sh;
    logic [31:0] jj;
    total = ((n + 8) / 64 + 1) * 64;
    jj = j;
    if (j < n) return jj[7:0];
    if (j == n) return 8'h80;
    if (j >= total - 8) begin
      sh = (64'(n) * 64'd8) >> ((total - 1 - j) * 8);
      return sh[7:0];
    end
    return 8'h00;
  endfunction

  function automatic logic [511:0] model_blk(input int n, input int b);
    logic [511:0] r;
    r = '0;
    for (int k = 0; k < 64; k++) r[511-8*k -: 8] = pad_byte(n, b*64 + k);
    return r;
  endfunction

  task automatic send(input logic [31:0] d, input logic last, input logic [2:0] nb);
    bit done;
    done = 1'b0;
    in_valid = 1'b1; in_data = d; in_last = last; in_bytes = nb;
    for (int t = 0; t < 100 && !done; t++) begin
      @(negedge clock);
      if (in_ready) begin
        @(posedge clock); #1;
        done = 1'b1;
      end
    end
    in_valid = 1'b0; in_last = 1'b0;
    if (!done) begin
      checks++; errors++;
      $error("FAIL send_timeout: word %0h not accepted, required acceptance within 100 cycles", d);
    end
  endtask

  task automatic recv(input int idx);
    bit got;
    got = 1'b0;
    for (int t = 0; t < 100 && !got; t++) begin
      @(negedge clock);
      if (blk_valid) begin
        rx_data[idx] = blk_data; rx_first[idx] = blk_first; rx_final[idx] = blk_final;
        blk_ready = 1'b1;
        @(posedge clock); #1;
        blk_ready = 1'b0;
        got = 1'b1;
      end
    end
    if (!got) begin
      checks++; errors++;
      rx_data[idx] = 'x; rx_first[idx] = 1'bx; rx_final[idx] = 1'bx;
      $error("FAIL recv_timeout: no block %0d, required blk_valid within 100 cycles", idx);
    end
  endtask

  // Message of n bytes (byte j = j); bytes past the end carry 0xEE garbage.
  task automatic send_msg(input int n);
    int nw, rem, idx;
    logic [31:0] d;
    nw = (n == 0) ? 1 : (n + 3) / 4;
    for (int w = 0; w < nw; w++) begin
      for (int j = 0; j < 4; j++) begin
        idx = 4*w + j;
        d[31-8*j -: 8] = (idx < n) ? idx[7:0] : 8'hEE;
      end
      rem = n - 4*w;
      send(d, w == nw - 1, (rem >= 4) ? 3'd4 : 3'(rem));
    end
  endtask

  task automatic run_msg(input int n);
    int nb;
    nb = (n + 8) / 64 + 1;
    send_msg(n);
    for (int b = 0; b < nb; b++) begin
      recv(b);
      chk($sformatf("msg%0d_blk%0d_data", n, b), rx_data[b], model_blk(n, b));
      chk($sformatf("msg%0d_blk%0d_first", n, b), 512'(rx_first[b]), 512'(b == 0));
      chk($sformatf("msg%0d_blk%0d_final", n, b), 512'(rx_final[b]), 512'(b == nb - 1));
    end
  endtask

  logic [511:0] exp_abc;

  initial begin
    exp_abc = '0;
    exp_abc[511:480] = 32'h61626380;
    exp_abc[31:0]    = 32'h00000018;

    // Reset values
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_in_ready", 512'(in_ready), 512'(0));
    chk("rst_blk_valid", 512'(blk_valid), 512'(0));
    chk("rst_blk_data", blk_data, 512'(0));
    chk("rst_blk_first", 512'(blk_first), 512'(1));
    chk("rst_blk_final", 512'(blk_final), 512'(0));
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("rdy_low_first_cycle", 512'(in_ready), 512'(0));
    @(posedge clock); #1;
    chk("rdy_rises", 512'(in_ready), 512'(1));

    // blk_ready with nothing pending has no effect
    blk_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1 blk_ready = 1'b0;
    chk("idle_ready_no_block", 512'(blk_valid), 512'(0));

    // "abc" with backpressure and a held, ignored input word
    send(32'h61626300, 1'b1, 3'd3);
    chk("abc_latency_valid", 512'(blk_valid), 512'(1));
    in_valid = 1'b1; in_data = 32'hDEADBEEF;
    for (int t = 0; t < 10; t++) begin
      @(negedge clock);
      chk($sformatf("bp_data_c%0d", t), blk_data, exp_abc);
      chk($sformatf("bp_in_ready_c%0d", t), 512'(in_ready), 512'(0));
    end
    in_valid = 1'b0;
    recv(0);
    chk("abc_data", rx_data[0], exp_abc);
    chk("abc_w0", 512'(wd(rx_data[0], 0)), 512'(32'h61626380));
    chk("abc_w15", 512'(wd(rx_data[0], 15)), 512'(32'h00000018));
    chk("abc_first", 512'(rx_first[0]), 512'(1));
    chk("abc_final", 512'(rx_final[0]), 512'(1));
    chk("abc_next_rdy", 512'(in_ready), 512'(1));
    chk("abc_next_novalid", 512'(blk_valid), 512'(0));

    // Empty message
    send(32'h12345678, 1'b1, 3'd0);
    recv(0);
    chk("empty_data", rx_data[0], {32'h80000000, 480'h0});
    chk("empty_first", 512'(rx_first[0]), 512'(1));
    chk("empty_final", 512'(rx_final[0]), 512'(1));

    // in_bytes above 4 counts as 4: "abcd"
    send(32'h61626364, 1'b1, 3'd7);
    recv(0);
    chk("b7_w0", 512'(wd(rx_data[0], 0)), 512'(32'h61626364));
    chk("b7_w1", 512'(wd(rx_data[0], 1)), 512'(32'h80000000));
    chk("b7_w15", 512'(wd(rx_data[0], 15)), 512'(32'h00000020));

    // 55 bytes: single block, marker in last byte of word 13
    run_msg(55);
    chk("m55_w13", 512'(wd(rx_data[0], 13)), 512'(32'h34353680));
    chk("m55_w15", 512'(wd(rx_data[0], 15)), 512'(32'h000001B8));

    // 56 bytes: marker spills, length in a second block
    run_msg(56);
    chk("m56_b0_w14", 512'(wd(rx_data[0], 14)), 512'(32'h80000000));
    chk("m56_b0_w15", 512'(wd(rx_data[0], 15)), 512'(32'h00000000));
    chk("m56_b1", rx_data[1], 512'h1C0);

    // 64 bytes: data block, then marker+length block
    run_msg(64);
    chk("m64_b0_w15", 512'(wd(rx_data[0], 15)), 512'(32'h3C3D3E3F));
    chk("m64_b1", rx_data[1], {32'h80000000, 416'h0, 64'h200});

    // Reset mid-message
    for (int w = 0; w < 7; w++) send(32'hA5A5A5A5 ^ 32'(w), 1'b0, 3'd4);
    reset = 1'b1;
    @(posedge clock); #1;
    chk("midrst_in_ready", 512'(in_ready), 512'(0));
    chk("midrst_blk_valid", 512'(blk_valid), 512'(0));
    chk("midrst_blk_data", blk_data, 512'(0));
    chk("midrst_blk_first", 512'(blk_first), 512'(1));
    chk("midrst_blk_final", 512'(blk_final), 512'(0));
    reset = 1'b0;
    send(32'h61626300, 1'b1, 3'd3);
    recv(0);
    chk("postrst_abc", rx_data[0], exp_abc);
    chk("postrst_first", 512'(rx_first[0]), 512'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
